// File: rtl/logic_clock_domain_crossing_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter in front of the CDC Rx port.
// Optional feature macro: LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN.
package logic_clock_domain_crossing_arbiter_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/logic_clock_domain_crossing_arbiter_if.sv
// AXI4-Stream bundle between INPUTS Rx sources and the single tagged Tx channel.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface logic_clock_domain_crossing_arbiter_if #(
   parameter int unsigned INPUTS = 4,
   parameter int unsigned WIDTH  = 1
);
   import logic_clock_domain_crossing_arbiter_pkg::*;

   localparam int unsigned ID_WIDTH = id_width(INPUTS);

   logic [INPUTS-1:0]            rx_tvalid;
   logic [INPUTS-1:0]            rx_tlast;
   logic [INPUTS-1:0][WIDTH-1:0] rx_tdata;
   logic [INPUTS-1:0]            rx_tready;
   logic                         tx_tready;
   logic                         tx_tvalid;
   logic                         tx_tlast;
   logic [WIDTH-1:0]             tx_tdata;
   logic [ID_WIDTH-1:0]          tx_tid;

   modport master (
      output rx_tvalid, rx_tlast, rx_tdata, tx_tready,
      input  rx_tready, tx_tvalid, tx_tlast, tx_tdata, tx_tid
   );

   modport slave (
      input  rx_tvalid, rx_tlast, rx_tdata, tx_tready,
      output rx_tready, tx_tvalid, tx_tlast, tx_tdata, tx_tid
   );

endinterface

// File: rtl/logic_clock_domain_crossing_arbiter_round_robin.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module logic_clock_domain_crossing_arbiter_round_robin
   import logic_clock_domain_crossing_arbiter_pkg::*;
#(
   parameter  int unsigned INPUTS   = 4,
   localparam int unsigned ID_WIDTH = id_width(INPUTS)
) (
   input  logic [INPUTS-1:0]   req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [INPUTS-1:0]   grant,
   output logic [ID_WIDTH-1:0] idx
);

   always_comb begin
      logic [ID_WIDTH-1:0] cand;
      logic                found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < INPUTS; k++) begin
         cand = ID_WIDTH'((32'(ptr) + k) % INPUTS);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/logic_clock_domain_crossing_arbiter.sv
// Round-robin AXI4-Stream arbiter with packet lock on tlast and registered, tid-tagged output.
// Optional lock timeout: LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN.
module logic_clock_domain_crossing_arbiter
   import logic_clock_domain_crossing_arbiter_pkg::*;
#(
   parameter int unsigned INPUTS = 4,
   parameter int unsigned WIDTH  = 1
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 256
`endif
) (
   input logic aclk,
   input logic areset_n,
   logic_clock_domain_crossing_arbiter_if.slave bus
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN
   ,
   output logic tx_timeout
`endif
);

   localparam int unsigned ID_WIDTH = id_width(INPUTS);

   state_t              state_q, state_d;
   logic [ID_WIDTH-1:0] ptr_q, ptr_d, lock_q, lock_d;
   logic [ID_WIDTH-1:0] rr_idx, sel;
   logic [INPUTS-1:0]   rr_grant, grant, rx_tready;
   logic                load, accept, sel_last;

   logic                tv_q, tv_d, tl_q, tl_d;
   logic [WIDTH-1:0]    td_q, td_d;
   logic [ID_WIDTH-1:0] tid_q, tid_d;

   logic_clock_domain_crossing_arbiter_round_robin #(
      .INPUTS (INPUTS)
   ) u_round_robin (
      .req   (bus.rx_tvalid),
      .ptr   (ptr_q),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   // While locked the grant ignores other requests, even if the locked source goes idle.
   always_comb begin
      grant = '0;
      sel   = rr_idx;
      if (state_q == LOCKED) begin
         grant[lock_q] = 1'b1;
         sel           = lock_q;
      end else begin
         grant = rr_grant;
      end
   end

   assign load      = !tv_q || bus.tx_tready;
   assign rx_tready = load ? grant : '0;
   assign accept    = |(bus.rx_tvalid & rx_tready);
   assign sel_last  = bus.rx_tlast[sel];

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN
   localparam int unsigned CNT_WIDTH = id_width(TIMEOUT);
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 to_q, to_d;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      tv_d    = tv_q;
      tl_d    = tl_q;
      td_d    = td_q;
      tid_d   = tid_q;

      if (load) begin
         tv_d = accept;
         if (accept) begin
            tl_d  = sel_last;
            td_d  = bus.rx_tdata[sel];
            tid_d = sel;
         end
      end

      if (accept) begin
         if (sel_last) begin
            state_d = IDLE;
            ptr_d   = ID_WIDTH'(wrap_inc(32'(sel), INPUTS));
         end else begin
            state_d = LOCKED;
            lock_d  = sel;
         end
      end

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN
      cnt_d = '0;
      to_d  = 1'b0;
      if (state_q == LOCKED && !accept) begin
         cnt_d = cnt_q;
         if (!bus.rx_tvalid[lock_q]) begin
            if (cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
               // Abandon the packet without a tlast; the far side sees the pulse instead.
               cnt_d   = '0;
               to_d    = 1'b1;
               state_d = IDLE;
               ptr_d   = ID_WIDTH'(wrap_inc(32'(lock_q), INPUTS));
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
`endif
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
         tv_q    <= 1'b0;
         tl_q    <= 1'b0;
         td_q    <= '0;
         tid_q   <= '0;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN
         cnt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         tv_q    <= tv_d;
         tl_q    <= tl_d;
         td_q    <= td_d;
         tid_q   <= tid_d;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN
         cnt_q   <= cnt_d;
         to_q    <= to_d;
`endif
      end
   end

   assign bus.rx_tready = rx_tready;
   assign bus.tx_tvalid = tv_q;
   assign bus.tx_tlast  = tl_q;
   assign bus.tx_tdata  = td_q;
   assign bus.tx_tid    = tid_q;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ARBITER_TIMEOUT_EN
   assign tx_timeout    = to_q;
`endif

endmodule
